// File: rtl/gf256_inv_out_mul.sv
// Output-multiplication stage of a two-share masked GF(2^8) inverter: forms
// {d*al, d*ah} from the masked GF(2^4) inverse and the delayed input nibbles.
module gf256_inv_out_mul (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    input  logic [3:0] ah0,
    input  logic [3:0] ah1,
    input  logic [3:0] al0,
    input  logic [3:0] al1,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] rh,
    input  logic [3:0] rl,
    output logic [7:0] out0,
    output logic [7:0] out1,
    output logic       out_valid
);

    // GF(2^4) multiply in the polynomial basis of x^4 + x + 1, the same
    // basis the upstream inverter stage produces d in.
    function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                p[i+j] = p[i+j] ^ (a[i] & b[j]);
            end
        end
        gf16_mul = {p[3] ^ p[6],
                    p[2] ^ p[5] ^ p[6],
                    p[1] ^ p[4] ^ p[5],
                    p[0] ^ p[4]};
    endfunction

    // Register set A: nibble shares delayed to line up with d
    logic [3:0] r_ahq0;
    logic [3:0] r_ahq1;
    logic [3:0] r_alq0;
    logic [3:0] r_alq1;
    logic       r_vq;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ahq0 <= 4'h0;
            r_ahq1 <= 4'h0;
            r_alq0 <= 4'h0;
            r_alq1 <= 4'h0;
            r_vq   <= 1'b0;
        end else begin
            r_ahq0 <= ah0;
            r_ahq1 <= ah1;
            r_alq0 <= al0;
            r_alq1 <= al1;
            r_vq   <= in_valid;
        end
    end

    // Inner and cross-domain partial products; cross terms masked before the register
    logic [3:0] w_h00;
    logic [3:0] w_h01;
    logic [3:0] w_h10;
    logic [3:0] w_h11;
    logic [3:0] w_l00;
    logic [3:0] w_l01;
    logic [3:0] w_l10;
    logic [3:0] w_l11;

    assign w_h00 = gf16_mul(d0, r_alq0);
    assign w_h01 = gf16_mul(d0, r_alq1) ^ rh;
    assign w_h10 = gf16_mul(d1, r_alq0) ^ rh;
    assign w_h11 = gf16_mul(d1, r_alq1);
    assign w_l00 = gf16_mul(d0, r_ahq0);
    assign w_l01 = gf16_mul(d0, r_ahq1) ^ rl;
    assign w_l10 = gf16_mul(d1, r_ahq0) ^ rl;
    assign w_l11 = gf16_mul(d1, r_ahq1);

    // Register set B: every term held separately so no share domains merge
    (* keep = "true" *) logic [3:0] r_h00;
    (* keep = "true" *) logic [3:0] r_h01;
    (* keep = "true" *) logic [3:0] r_h10;
    (* keep = "true" *) logic [3:0] r_h11;
    (* keep = "true" *) logic [3:0] r_l00;
    (* keep = "true" *) logic [3:0] r_l01;
    (* keep = "true" *) logic [3:0] r_l10;
    (* keep = "true" *) logic [3:0] r_l11;
    logic                           r_out_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_h00       <= 4'h0;
            r_h01       <= 4'h0;
            r_h10       <= 4'h0;
            r_h11       <= 4'h0;
            r_l00       <= 4'h0;
            r_l01       <= 4'h0;
            r_l10       <= 4'h0;
            r_l11       <= 4'h0;
            r_out_valid <= 1'b0;
        end else begin
            r_h00       <= w_h00;
            r_h01       <= w_h01;
            r_h10       <= w_h10;
            r_h11       <= w_h11;
            r_l00       <= w_l00;
            r_l01       <= w_l01;
            r_l10       <= w_l10;
            r_l11       <= w_l11;
            r_out_valid <= r_vq;
        end
    end

    // Compression: the rh/rl masks cancel only in out0 ^ out1
    assign out0      = {r_h00 ^ r_h01, r_l00 ^ r_l01};
    assign out1      = {r_h10 ^ r_h11, r_l10 ^ r_l11};
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_gf256_inv_out_mul.sv
// Bench for gf256_inv_out_mul: driver pushes {due cycle, out0, out1} per live
// input, a negedge monitor pops and compares whenever out_valid is seen.
module tb_gf256_inv_out_mul;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       in_valid = 1'b0;
    logic [3:0] ah0 = '0, ah1 = '0, al0 = '0, al1 = '0;
    logic [3:0] d0 = '0, d1 = '0, rh = '0, rl = '0;
    logic [7:0] out0, out1;
    logic       out_valid;

    gf256_inv_out_mul dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid),
        .ah0(ah0), .ah1(ah1), .al0(al0), .al1(al1),
        .d0(d0), .d1(d1), .rh(rh), .rl(rl),
        .out0(out0), .out1(out1), .out_valid(out_valid)
    );

    // clock / reset bookkeeping
    always #5 CLK = ~CLK;

    int   cyc = 0;
    logic rst_q = 1'b0;
    always @(posedge CLK) begin
        cyc   <= cyc + 1;
        rst_q <= RST;
    end

    int checks = 0;
    int errors = 0;

    // scoreboard entry: {due cycle, out0, out1}
    logic [47:0] exp_q[$];

    typedef struct {
        logic       v;
        logic [3:0] ah0, ah1, al0, al1, d0, d1, rh, rl;
    } vec_t;

    vec_t pend;

    // reference GF(2^4) multiply, x^4 + x + 1, shift-and-add form
    function automatic logic [3:0] m_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x, r;
        x = a;
        r = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (b[k]) r = r ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
        end
        return r;
    endfunction

    function automatic logic [3:0] m_inv(input logic [3:0] a);
        logic [3:0] r;
        r = 4'h0;
        for (int k = 1; k < 16; k++) begin
            if (m_mul(a, 4'(k)) == 4'h1) r = 4'(k);
        end
        return r;
    endfunction

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    // monitor
    always @(negedge CLK) begin
        logic [47:0] e;
        if (rst_q) begin
            check8("rst_out0", out0, 8'h00);
            check8("rst_out1", out1, 8'h00);
            check8("rst_valid", {7'h0, out_valid}, 8'h00);
        end
        while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid cyc=%0d got=none want_due=%0d", cyc, int'(e[47:16]));
        end
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0 || int'(exp_q[0][47:16]) != cyc) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid cyc=%0d got=1 want=0", cyc);
            end else begin
                e = exp_q.pop_front();
                check8("out0", out0, e[15:8]);
                check8("out1", out1, e[7:0]);
                check8("out_xor", out0 ^ out1, e[15:8] ^ e[7:0]);
            end
        end
    end

    // driver: presents vector x (ah/al this cycle) and the previous vector's d/rh/rl
    task automatic drive(input vec_t x, input logic rst, input logic [7:0] e0, input logic [7:0] e1);
        logic [47:0] keep_q[$];
        RST      = rst;
        in_valid = x.v;
        ah0 = x.ah0; ah1 = x.ah1; al0 = x.al0; al1 = x.al1;
        d0  = pend.d0; d1 = pend.d1; rh = pend.rh; rl = pend.rl;
        if (rst) begin
            keep_q = {};
            foreach (exp_q[k]) if (int'(exp_q[k][47:16]) <= cyc) keep_q.push_back(exp_q[k]);
            exp_q = keep_q;
        end else if (x.v) begin
            exp_q.push_back({32'(cyc + 2), e0, e1});
        end
        pend = x;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [15:0] model(input vec_t x);
        logic [3:0] al, ah;
        al = x.al0 ^ x.al1;
        ah = x.ah0 ^ x.ah1;
        return {m_mul(x.d0, al) ^ x.rh, m_mul(x.d0, ah) ^ x.rl,
                m_mul(x.d1, al) ^ x.rh, m_mul(x.d1, ah) ^ x.rl};
    endfunction

    function automatic vec_t rnd_vec(input logic v, input logic [3:0] ah, input logic [3:0] al);
        vec_t x;
        logic [3:0] d;
        x.v   = v;
        x.ah0 = 4'($urandom_range(0, 15)); x.ah1 = ah ^ x.ah0;
        x.al0 = 4'($urandom_range(0, 15)); x.al1 = al ^ x.al0;
        d     = m_inv(ah ^ al);
        x.d0  = 4'($urandom_range(0, 15)); x.d1 = d ^ x.d0;
        x.rh  = 4'($urandom_range(0, 15));
        x.rl  = 4'($urandom_range(0, 15));
        return x;
    endfunction

    // hand-computed directed vectors: {v, ah0, ah1, al0, al1, d0, d1, rh, rl} and expected shares
    vec_t       dir_v[6];
    logic [7:0] dir_e0[6];
    logic [7:0] dir_e1[6];

    initial begin
        vec_t       x;
        logic [15:0] m;
        dir_v[0] = '{1'b1, 4'h5, 4'h5, 4'hA, 4'hA, 4'h7, 4'hC, 4'h3, 4'hC}; dir_e0[0] = 8'h3C; dir_e1[0] = 8'h3C;
        dir_v[1] = '{1'b1, 4'h2, 4'h0, 4'h8, 4'h0, 4'h2, 4'h0, 4'h0, 4'h0}; dir_e0[1] = 8'h34; dir_e1[1] = 8'h00;
        dir_v[2] = '{1'b1, 4'h3, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0, 4'h0}; dir_e0[2] = 8'hA2; dir_e1[2] = 8'h00;
        dir_v[3] = '{1'b1, 4'h1, 4'h0, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0}; dir_e0[3] = 8'hC8; dir_e1[3] = 8'h00;
        dir_v[4] = '{1'b1, 4'h7, 4'h5, 4'hC, 4'h4, 4'h3, 4'h1, 4'h6, 4'h9}; dir_e0[4] = 8'hDF; dir_e1[4] = 8'hEB;
        dir_v[5] = '{1'b1, 4'h1, 4'h2, 4'h5, 4'hA, 4'h9, 4'h6, 4'hA, 4'h5}; dir_e0[5] = 8'h4D; dir_e1[5] = 8'hEF;
        pend = '{1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

        // reset held two cycles with random live-looking inputs
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) drive(rnd_vec(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))), 1'b1, 8'h00, 8'h00);

        // directed, back to back
        for (int i = 0; i < 6; i++) drive(dir_v[i], 1'b0, dir_e0[i], dir_e1[i]);

        // directed with alternating valid gaps
        for (int i = 0; i < 6; i++) begin
            drive(dir_v[i], 1'b0, dir_e0[i], dir_e1[i]);
            x = rnd_vec(1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            drive(x, 1'b0, 8'h00, 8'h00);
        end

        // all 256 (ah, al) pairs streamed
        for (int i = 0; i < 256; i++) begin
            x = rnd_vec(1'b1, 4'(i >> 4), 4'(i));
            m = model(x);
            drive(x, 1'b0, m[15:8], m[7:0]);
        end

        // one-cycle reset in the middle of a stream
        for (int i = 0; i < 16; i++) begin
            x = rnd_vec(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            m = model(x);
            drive(x, (i == 8), m[15:8], m[7:0]);
        end

        // drain
        for (int i = 0; i < 4; i++) begin
            x = rnd_vec(1'b0, 4'h0, 4'h0);
            drive(x, 1'b0, 8'h00, 8'h00);
        end
        @(negedge CLK);
        check8("queue_empty", 8'(exp_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
